// File: rtl/axi_sram_pkg.sv
// Shared types for the AXI SRAM responder: FSM states, AXI response/burst codes, response merging.
package axi_sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WRESP = 2'd2,
    ST_READ  = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // The three codes in use are numerically ordered by severity.
  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_sram_array.sv
// Flop-array word memory: byte-enable synchronous write, combinational read, no reset.
// Optional per-word user field when AXI_SRAM_RESP_USER_EN is defined.
module axi_sram_array #(
  parameter int DataWidth = 64,
`ifdef AXI_SRAM_RESP_USER_EN
  parameter int UserWidth = 32,
`endif
  parameter int MemWords  = 1024,
  parameter int IdxW      = $clog2(MemWords)
)(
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [IdxW-1:0]        waddr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
`ifdef AXI_SRAM_RESP_USER_EN
  input  logic                   user_we_i,
  input  logic [UserWidth-1:0]   wuser_i,
  output logic [UserWidth-1:0]   ruser_o,
`endif
  input  logic [IdxW-1:0]        raddr_i,
  output logic [DataWidth-1:0]   rdata_o
);

  logic [DataWidth-1:0] r_mem [MemWords];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DataWidth/8; b++) begin
        if (wstrb_i[b]) r_mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = r_mem[raddr_i];

`ifdef AXI_SRAM_RESP_USER_EN
  logic [UserWidth-1:0] r_user [MemWords];

  always_ff @(posedge clk_i) begin
    if (user_we_i) r_user[waddr_i] <= wuser_i;
  end

  assign ruser_o = r_user[raddr_i];
`endif

endmodule

// File: rtl/axi_sram_responder.sv
// AXI4 subordinate over a local SRAM, one transaction at a time; R beat 0 the cycle after AR, B the cycle
// after WLAST; R/B payload held while the manager stalls. User storage only with AXI_SRAM_RESP_USER_EN.
module axi_sram_responder
  import axi_sram_pkg::*;
#(
  parameter int                   AddrWidth = 64,
  parameter int                   DataWidth = 64,
  parameter int                   IdWidth   = 4,
  parameter int                   UserWidth = 32,
  parameter int                   MemWords  = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr  = 64'h8000_0000
)(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   aw_valid_i,
  output logic                   aw_ready_o,
  input  logic [IdWidth-1:0]     aw_id_i,
  input  logic [AddrWidth-1:0]   aw_addr_i,
  input  logic [7:0]             aw_len_i,
  input  logic [2:0]             aw_size_i,
  input  logic [1:0]             aw_burst_i,
  input  logic [5:0]             aw_atop_i,
  input  logic                   w_valid_i,
  output logic                   w_ready_o,
  input  logic [DataWidth-1:0]   w_data_i,
  input  logic [DataWidth/8-1:0] w_strb_i,
  input  logic [UserWidth-1:0]   w_user_i,
  input  logic                   w_last_i,
  output logic                   b_valid_o,
  input  logic                   b_ready_i,
  output logic [IdWidth-1:0]     b_id_o,
  output logic [1:0]             b_resp_o,
  input  logic                   ar_valid_i,
  output logic                   ar_ready_o,
  input  logic [IdWidth-1:0]     ar_id_i,
  input  logic [AddrWidth-1:0]   ar_addr_i,
  input  logic [7:0]             ar_len_i,
  input  logic [2:0]             ar_size_i,
  input  logic [1:0]             ar_burst_i,
  output logic                   r_valid_o,
  input  logic                   r_ready_i,
  output logic [IdWidth-1:0]     r_id_o,
  output logic [DataWidth-1:0]   r_data_o,
  output logic [1:0]             r_resp_o,
  output logic [UserWidth-1:0]   r_user_o,
  output logic                   r_last_o
);

  localparam int                   OffW        = $clog2(DataWidth/8);
  localparam int                   IdxW        = $clog2(MemWords);
  localparam logic [AddrWidth-1:0] MEM_WORDS_A = AddrWidth'(MemWords);

  state_e               r_state;
  logic                 r_rr_wr;
  logic [7:0]           r_len;
  logic                 r_req_err;
  logic [AddrWidth-1:0] r_idx;
  logic [8:0]           r_beat;
  logic [1:0]           r_wresp;
  logic                 r_b_valid;
  logic [IdWidth-1:0]   r_b_id;
  logic [1:0]           r_b_resp;
  logic                 r_r_valid;
  logic [IdWidth-1:0]   r_r_id;
  logic [DataWidth-1:0] r_r_data;
  logic [1:0]           r_r_resp;
  logic                 r_r_last;

  // Both channels are ready in IDLE; on a simultaneous request only the round-robin winner sees ready.
  logic w_idle_ok, w_both, w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
  assign w_idle_ok  = (r_state == ST_IDLE) && !rst_i;
  assign w_both     = aw_valid_i && ar_valid_i;
  assign aw_ready_o = w_idle_ok && !(w_both && !r_rr_wr);
  assign ar_ready_o = w_idle_ok && !(w_both && r_rr_wr);
  assign w_ready_o  = (r_state == ST_WRITE) && !rst_i;
  assign w_aw_hs    = aw_valid_i && aw_ready_o;
  assign w_ar_hs    = ar_valid_i && ar_ready_o;
  assign w_w_hs     = w_valid_i && w_ready_o;
  assign w_r_hs     = r_r_valid && r_ready_i;

  logic [AddrWidth-1:0] w_aw_idx, w_ar_idx;
  logic                 w_aw_err, w_ar_err;
  assign w_aw_idx = (aw_addr_i - BaseAddr) >> OffW;
  assign w_ar_idx = (ar_addr_i - BaseAddr) >> OffW;
  assign w_aw_err = (aw_burst_i != BURST_INCR) || (aw_size_i != 3'(OffW)) || (aw_atop_i != 6'd0);
  assign w_ar_err = (ar_burst_i != BURST_INCR) || (ar_size_i != 3'(OffW));

  // Write beat: beats past len are discarded; a misplaced or missing WLAST flags SLVERR.
  logic       w_w_inlen, w_w_proto, w_mem_we;
  logic [1:0] w_w_base, w_w_resp;
  assign w_w_inlen = (r_beat <= {1'b0, r_len});
  assign w_w_proto = (w_last_i != (r_beat == {1'b0, r_len}));
  assign w_w_base  = (!w_w_inlen || r_req_err) ? RESP_SLVERR :
                     (r_idx >= MEM_WORDS_A)    ? RESP_DECERR : RESP_OKAY;
  assign w_w_resp  = worst_resp(w_w_base, w_w_proto ? RESP_SLVERR : RESP_OKAY);
  assign w_mem_we  = w_w_hs && w_w_inlen && !r_req_err && (r_idx < MEM_WORDS_A);

  // Read beat source: the AR request in IDLE, the next burst index while streaming.
  logic [AddrWidth-1:0] w_rd_idx;
  logic [1:0]           w_rd_resp;
  logic                 w_rd_ok;
  logic [DataWidth-1:0] w_mem_rdata;
  assign w_rd_idx  = (r_state == ST_IDLE) ? w_ar_idx : r_idx;
  assign w_rd_resp = ((r_state == ST_IDLE) ? w_ar_err : r_req_err) ? RESP_SLVERR :
                     (w_rd_idx >= MEM_WORDS_A) ? RESP_DECERR : RESP_OKAY;
  assign w_rd_ok   = (w_rd_resp == RESP_OKAY);

`ifdef AXI_SRAM_RESP_USER_EN
  logic [UserWidth-1:0] w_mem_ruser;
  logic [UserWidth-1:0] r_r_user;
  assign r_user_o = r_r_user;
`else
  logic w_unused_user;
  assign w_unused_user = ^w_user_i;
  assign r_user_o      = '0;
`endif

  axi_sram_array #(
    .DataWidth (DataWidth),
`ifdef AXI_SRAM_RESP_USER_EN
    .UserWidth (UserWidth),
`endif
    .MemWords  (MemWords),
    .IdxW      (IdxW)
  ) u_array (
    .clk_i     (clk_i),
    .we_i      (w_mem_we),
    .waddr_i   (r_idx[IdxW-1:0]),
    .wdata_i   (w_data_i),
    .wstrb_i   (w_strb_i),
`ifdef AXI_SRAM_RESP_USER_EN
    .user_we_i (w_mem_we && (|w_strb_i)),
    .wuser_i   (w_user_i),
    .ruser_o   (w_mem_ruser),
`endif
    .raddr_i   (w_rd_idx[IdxW-1:0]),
    .rdata_o   (w_mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_rr_wr   <= 1'b1;
      r_len     <= '0;
      r_req_err <= 1'b0;
      r_idx     <= '0;
      r_beat    <= '0;
      r_wresp   <= RESP_OKAY;
      r_b_valid <= 1'b0;
      r_b_id    <= '0;
      r_b_resp  <= RESP_OKAY;
      r_r_valid <= 1'b0;
      r_r_id    <= '0;
      r_r_data  <= '0;
      r_r_resp  <= RESP_OKAY;
      r_r_last  <= 1'b0;
`ifdef AXI_SRAM_RESP_USER_EN
      r_r_user  <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_aw_hs) begin
            r_state   <= ST_WRITE;
            r_rr_wr   <= !r_rr_wr;
            r_b_id    <= aw_id_i;
            r_len     <= aw_len_i;
            r_req_err <= w_aw_err;
            r_idx     <= w_aw_idx;
            r_beat    <= '0;
            r_wresp   <= RESP_OKAY;
          end else if (w_ar_hs) begin
            r_state   <= ST_READ;
            r_rr_wr   <= !r_rr_wr;
            r_r_id    <= ar_id_i;
            r_len     <= ar_len_i;
            r_req_err <= w_ar_err;
            r_idx     <= w_ar_idx + AddrWidth'(1);
            r_beat    <= '0;
            r_r_valid <= 1'b1;
            r_r_data  <= w_rd_ok ? w_mem_rdata : '0;
            r_r_resp  <= w_rd_resp;
            r_r_last  <= (ar_len_i == 8'd0);
`ifdef AXI_SRAM_RESP_USER_EN
            r_r_user  <= w_rd_ok ? w_mem_ruser : '0;
`endif
          end
        end
        ST_WRITE: begin
          if (w_w_hs) begin
            r_idx <= r_idx + AddrWidth'(1);
            if (r_beat != 9'h1ff) r_beat <= r_beat + 9'd1;
            if (w_last_i) begin
              r_state   <= ST_WRESP;
              r_b_valid <= 1'b1;
              r_b_resp  <= worst_resp(r_wresp, w_w_resp);
            end else begin
              r_wresp <= worst_resp(r_wresp, w_w_resp);
            end
          end
        end
        ST_WRESP: begin
          if (b_ready_i) begin
            r_state   <= ST_IDLE;
            r_b_valid <= 1'b0;
          end
        end
        ST_READ: begin
          if (w_r_hs) begin
            if (r_r_last) begin
              r_state   <= ST_IDLE;
              r_r_valid <= 1'b0;
            end else begin
              r_idx    <= r_idx + AddrWidth'(1);
              r_beat   <= r_beat + 9'd1;
              r_r_data <= w_rd_ok ? w_mem_rdata : '0;
              r_r_resp <= w_rd_resp;
              r_r_last <= (r_beat[7:0] + 8'd1 == r_len);
`ifdef AXI_SRAM_RESP_USER_EN
              r_r_user <= w_rd_ok ? w_mem_ruser : '0;
`endif
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign b_valid_o = r_b_valid;
  assign b_id_o    = r_b_id;
  assign b_resp_o  = r_b_resp;
  assign r_valid_o = r_r_valid;
  assign r_id_o    = r_r_id;
  assign r_data_o  = r_r_data;
  assign r_resp_o  = r_r_resp;
  assign r_last_o  = r_r_last;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed + randomized bench for axi_sram_responder against an array/arithmetic reference model.
module tb_axi_sram_responder;

  localparam int          MW   = 1024;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [1:0]  OK = 2'b00, SLV = 2'b10, DEC = 2'b11;

  logic        clk = 1'b0, rst_i = 1'b1;
  logic        aw_valid_i = 0, aw_ready_o;
  logic [3:0]  aw_id_i = 0;
  logic [63:0] aw_addr_i = 0;
  logic [7:0]  aw_len_i = 0;
  logic [2:0]  aw_size_i = 0;
  logic [1:0]  aw_burst_i = 0;
  logic [5:0]  aw_atop_i = 0;
  logic        w_valid_i = 0, w_ready_o, w_last_i = 0;
  logic [63:0] w_data_i = 0;
  logic [7:0]  w_strb_i = 0;
  logic [31:0] w_user_i = 0;
  logic        b_valid_o, b_ready_i = 0;
  logic [3:0]  b_id_o;
  logic [1:0]  b_resp_o;
  logic        ar_valid_i = 0, ar_ready_o;
  logic [3:0]  ar_id_i = 0;
  logic [63:0] ar_addr_i = 0;
  logic [7:0]  ar_len_i = 0;
  logic [2:0]  ar_size_i = 0;
  logic [1:0]  ar_burst_i = 0;
  logic        r_valid_o, r_ready_i = 0, r_last_o;
  logic [3:0]  r_id_o;
  logic [63:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic [31:0] r_user_o;

  axi_sram_responder dut (
    .clk_i(clk), .rst_i(rst_i),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i), .aw_atop_i(aw_atop_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_user_i(w_user_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_user_o(r_user_o), .r_last_o(r_last_o)
  );

  always #5 clk = ~clk;

  int          n_vec = 0, n_err = 0;
  logic [63:0] mdl  [MW];
  logic [31:0] umdl [MW];
  logic [63:0] wdat [257];
  logic [7:0]  wstr [257];
  logic [31:0] wusr [257];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int sev(input logic [1:0] r);
    return (r == DEC) ? 2 : (r == SLV) ? 1 : 0;
  endfunction

  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    return (sev(a) >= sev(b)) ? a : b;
  endfunction

  // Applies a write transaction to the model and returns the B response it must produce.
  function automatic logic [1:0] mdl_write(input logic [63:0] addr, input int len, input logic [1:0] burst,
                                           input logic [2:0] size, input logic [5:0] atop, input int last_at);
    logic [1:0]  resp = OK;
    logic [63:0] idx;
    bit bad = (burst != 2'b01) || (size != 3'd3) || (atop != 6'd0);
    if (bad || last_at != len) resp = SLV;
    for (int k = 0; k <= last_at && k <= len; k++) begin
      idx = (addr - BASE) / 8 + 64'(k);
      if (!bad && idx >= MW) resp = worse(resp, DEC);
      else if (!bad) begin
        for (int b = 0; b < 8; b++)
          if (wstr[k][b]) mdl[idx[9:0]][b*8 +: 8] = wdat[k][b*8 +: 8];
        if (wstr[k] != 8'h00) umdl[idx[9:0]] = wusr[k];
      end
    end
    return resp;
  endfunction

  task automatic aw_hs(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [2:0] size, input logic [5:0] atop);
    bit got = 0;
    aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_burst_i = burst; aw_size_i = size;
    aw_atop_i = atop; aw_valid_i = 1;
    for (int c = 0; c < 100 && !got; c++) begin #1; got = aw_ready_o; tick(); end
    aw_valid_i = 0;
    chk("aw_accept", 64'(got), 1);
  endtask

  task automatic w_phase(input int last_at);
    bit got;
    for (int k = 0; k <= last_at; k++) begin
      got = 0;
      w_data_i = wdat[k]; w_strb_i = wstr[k]; w_user_i = wusr[k];
      w_last_i = (k == last_at); w_valid_i = 1;
      for (int c = 0; c < 100 && !got; c++) begin #1; got = w_ready_o; tick(); end
      if (!got) chk("w_accept", 64'(got), 1);
    end
    w_valid_i = 0; w_last_i = 0;
  endtask

  task automatic b_phase(input logic [3:0] id, input logic [1:0] resp);
    bit got = 0;
    logic [3:0] bid = 0;
    logic [1:0] bresp = 0;
    chk("b_valid_after_wlast", 64'(b_valid_o), 1);
    b_ready_i = 1;
    for (int c = 0; c < 100 && !got; c++) begin
      #1; got = b_valid_o; bid = b_id_o; bresp = b_resp_o; tick();
    end
    b_ready_i = 0;
    chk("b_handshake", 64'(got), 1);
    chk("b_id", 64'(bid), 64'(id));
    chk("b_resp", 64'(bresp), 64'(resp));
    chk("aw_ready_after_b", 64'(aw_ready_o), 1);
  endtask

  task automatic ar_hs(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [2:0] size);
    bit got = 0;
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_burst_i = burst; ar_size_i = size; ar_valid_i = 1;
    for (int c = 0; c < 100 && !got; c++) begin #1; got = ar_ready_o; tick(); end
    ar_valid_i = 0;
    chk("ar_accept", 64'(got), 1);
    chk("r_valid_after_ar", 64'(r_valid_o), 1);
  endtask

  task automatic r_phase(input logic [3:0] id, input logic [63:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size, input bit toggle);
    bit          bad = (burst != 2'b01) || (size != 3'd3);
    bit          stalled = 0;
    int          k = 0, cyc = 0;
    logic [63:0] idx, ed, sd = 0;
    logic [31:0] eu;
    logic [1:0]  er, sr = 0;
    logic        sl = 0;
    while (k <= len && cyc < 2000) begin
      r_ready_i = toggle ? cyc[0] : 1'b1;
      #1;
      if (stalled) begin
        chk("r_stall_valid", 64'(r_valid_o), 1);
        chk("r_stall_data", r_data_o, sd);
        chk("r_stall_resp_last", {r_resp_o, r_last_o}, {sr, sl});
      end
      stalled = r_valid_o && !r_ready_i;
      sd = r_data_o; sr = r_resp_o; sl = r_last_o;
      if (r_valid_o && r_ready_i) begin
        idx = (addr - BASE) / 8 + 64'(k);
        er  = bad ? SLV : (idx >= MW) ? DEC : OK;
        ed  = (er == OK) ? mdl[idx[9:0]] : 64'd0;
`ifdef AXI_SRAM_RESP_USER_EN
        eu  = (er == OK) ? umdl[idx[9:0]] : 32'd0;
`else
        eu  = 32'd0;
`endif
        chk("r_id", 64'(r_id_o), 64'(id));
        chk("r_data", r_data_o, ed);
        chk("r_resp", 64'(r_resp_o), 64'(er));
        chk("r_last", 64'(r_last_o), 64'(k == len));
        chk("r_user", 64'(r_user_o), 64'(eu));
        k++;
      end
      tick();
      cyc++;
    end
    r_ready_i = 0;
    chk("r_beat_count", 64'(k), 64'(len + 1));
    if (!toggle) chk("r_throughput_cycles", 64'(cyc), 64'(len + 1));
    chk("r_valid_done", 64'(r_valid_o), 0);
    chk("ar_ready_after_r", 64'(ar_ready_o), 1);
  endtask

  task automatic do_write(input logic [3:0] id, input logic [63:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input logic [5:0] atop, input int last_at);
    logic [1:0] exp = mdl_write(addr, len, burst, size, atop, last_at);
    aw_hs(id, addr, 8'(len), burst, size, atop);
    w_phase(last_at);
    b_phase(id, exp);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [63:0] addr, input int len,
                         input logic [1:0] burst, input logic [2:0] size, input bit toggle);
    ar_hs(id, addr, 8'(len), burst, size);
    r_phase(id, addr, len, burst, size, toggle);
  endtask

  task automatic rand_beats(input int n);
    for (int k = 0; k < n; k++) begin
      wdat[k] = {$urandom, $urandom}; wstr[k] = 8'hFF; wusr[k] = $urandom;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] e;
    int len, last_at, widx;
    logic [1:0] bu;
    logic [2:0] sz;

    // Reset: readies low while held, outputs quiet, readies high the first cycle after.
    repeat (3) tick();
    #1;
    chk("rst_aw_ready", 64'(aw_ready_o), 0);
    chk("rst_ar_ready", 64'(ar_ready_o), 0);
    chk("rst_valids", {b_valid_o, r_valid_o, w_ready_o}, 0);
    rst_i = 0;
    tick();
    chk("post_rst_readies", {aw_ready_o, ar_ready_o}, 2'b11);
    chk("post_rst_payload", {b_id_o, b_resp_o, r_id_o, r_resp_o, r_last_o}, 0);
    chk("post_rst_rdata_user", {r_data_o, r_user_o}, 0);

    // Fill the whole memory so every model word is known.
    for (int w = 0; w < 4; w++) begin
      rand_beats(256);
      do_write(4'(w), BASE + 64'(w * 256 * 8), 255, 2'b01, 3'd3, 6'd0, 255);
    end

    // Single write and read-back.
    wdat[0] = 64'h1122334455667788; wstr[0] = 8'hFF; wusr[0] = 32'hCAFE0001;
    do_write(4'd1, BASE + 64'h10, 0, 2'b01, 3'd3, 6'd0, 0);
    do_read(4'd2, BASE + 64'h10, 0, 2'b01, 3'd3, 0);

    // 4-beat write with a partial strobe on beat 2; read back while R is stalled every other cycle.
    rand_beats(4);
    wstr[2] = 8'h0F;
    do_write(4'd3, BASE, 3, 2'b01, 3'd3, 6'd0, 3);
    do_read(4'd4, BASE, 3, 2'b01, 3'd3, 1);

    // Simultaneous AW+AR twice: write wins, then read, then write.
    rand_beats(1);
    aw_id_i = 4'd5; aw_addr_i = BASE + 64'h40; aw_len_i = 0; aw_burst_i = 2'b01; aw_size_i = 3'd3; aw_atop_i = 0;
    ar_id_i = 4'd9; ar_addr_i = BASE + 64'h40; ar_len_i = 0; ar_burst_i = 2'b01; ar_size_i = 3'd3;
    aw_valid_i = 1; ar_valid_i = 1;
    #1;
    chk("rr1_aw_ready", 64'(aw_ready_o), 1);
    chk("rr1_ar_ready", 64'(ar_ready_o), 0);
    tick();
    aw_valid_i = 0;
    e = mdl_write(BASE + 64'h40, 0, 2'b01, 3'd3, 6'd0, 0);
    w_phase(0);
    b_phase(4'd5, e);
    aw_id_i = 4'd6; aw_addr_i = BASE + 64'h48; aw_valid_i = 1;
    #1;
    chk("rr2_ar_ready", 64'(ar_ready_o), 1);
    chk("rr2_aw_ready", 64'(aw_ready_o), 0);
    tick();
    ar_valid_i = 0;
    chk("rr2_r_valid", 64'(r_valid_o), 1);
    r_phase(4'd9, BASE + 64'h40, 0, 2'b01, 3'd3, 0);
    #1;
    chk("rr3_aw_ready", 64'(aw_ready_o), 1);
    rand_beats(1);
    do_write(4'd6, BASE + 64'h48, 0, 2'b01, 3'd3, 6'd0, 0);

    // Burst crossing the top of memory: second beat DECERR with zero data.
    do_read(4'd7, BASE + 64'(MW * 8 - 8), 1, 2'b01, 3'd3, 0);

    // Atomic write rejected; early WLAST flagged.
    rand_beats(2);
    do_write(4'd8, BASE + 64'h80, 1, 2'b01, 3'd3, 6'h20, 1);
    do_read(4'd8, BASE + 64'h80, 1, 2'b01, 3'd3, 0);
    rand_beats(2);
    do_write(4'd10, BASE + 64'hA0, 3, 2'b01, 3'd3, 6'd0, 1);
    do_read(4'd10, BASE + 64'hA0, 3, 2'b01, 3'd3, 0);

    // Randomized transactions, including out-of-range, below-base and malformed requests.
    for (int t = 0; t < 40; t++) begin
      len  = $urandom_range(0, 3);
      widx = ($urandom_range(0, 7) == 0) ? $urandom_range(MW - 3, MW + 3) : $urandom_range(0, MW - 1);
      bu   = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b01;
      sz   = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3;
      if ($urandom_range(0, 15) == 0) widx = -1;
      if ($urandom_range(0, 1) == 0) begin
        rand_beats(5);
        for (int k = 0; k < 5; k++) wstr[k] = 8'($urandom);
        last_at = len;
        if ($urandom_range(0, 5) == 0) last_at = len + 1;
        else if ($urandom_range(0, 5) == 0 && len > 0) last_at = len - 1;
        do_write(4'($urandom), BASE + 64'(widx) * 8, len, bu, sz, 6'd0, last_at);
      end else begin
        do_read(4'($urandom), BASE + 64'(widx) * 8, len, bu, sz, 1'($urandom));
      end
    end

    // Reset in the middle of an 8-beat read aborts it; earlier writes survive.
    ar_hs(4'd3, BASE, 8'd7, 2'b01, 3'd3);
    r_ready_i = 1;
    repeat (2) tick();
    rst_i = 1;
    tick();
    chk("rst_mid_r_valid", 64'(r_valid_o), 0);
    rst_i = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rst_mid_no_beats", 64'(r_valid_o), 0);
    end
    r_ready_i = 0;
    chk("rst_mid_aw_ready", 64'(aw_ready_o), 1);
    do_read(4'd11, BASE + 64'h10, 0, 2'b01, 3'd3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
